// File: rtl/ulpi_rx_link.sv
// ============================================================================
// Module   : ulpi_rx_link
// Purpose  : ULPI link-side receive path: bus turnaround, RX CMD decode,
//            packet data capture with length/overflow, register-read capture.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ulpi_rx_link #(
  parameter int MAX_PKT = 1024
) (
  input  logic        clk_usb_i,
  input  logic        sys_rst_n_i,
  input  logic        dir_i,
  input  logic        nxt_i,
  input  logic [7:0]  data_in_i,
  input  logic        rd_expect_i,
  output logic        phy_owns_bus_o,
  output logic [7:0]  rx_cmd_o,
  output logic        rx_cmd_valid_o,
  output logic [1:0]  linestate_o,
  output logic [1:0]  vbus_state_o,
  output logic        id_gnd_o,
  output logic        alt_int_o,
  output logic        rx_active_o,
  output logic        rx_error_o,
  output logic        host_disc_o,
  output logic [7:0]  pkt_data_o,
  output logic        pkt_valid_o,
  output logic        pkt_eop_o,
  output logic [10:0] pkt_len_o,
  output logic        pkt_ovf_o,
  output logic [7:0]  reg_data_o,
  output logic        reg_valid_o
);

  typedef enum logic [2:0] {
    LINK_OWN = 3'd0,
    TURN_IN  = 3'd1,
    PHY_CMD  = 3'd2,
    PKT      = 3'd3,
    REG_RD   = 3'd4,
    TURN_OUT = 3'd5
  } state_t;

  localparam logic [11:0] c_max_pkt = 12'(MAX_PKT);

  state_t      state_q;
  logic        dir_q;
  logic [7:0]  rx_cmd_q;
  logic        rx_cmd_valid_q;
  logic        rx_active_q;
  logic        rx_error_q;
  logic        host_disc_q;
  logic [7:0]  pkt_data_q;
  logic        pkt_valid_q;
  logic        pkt_eop_q;
  logic [10:0] pkt_len_q;
  logic        pkt_ovf_q;
  logic [7:0]  reg_data_q;
  logic        reg_valid_q;
  logic [10:0] count_q;

  logic       w_phy_state;
  logic       w_fall;
  logic       w_cmd;
  logic       w_byte;
  logic       w_reg_cap;
  logic       w_start_turn;
  logic       w_start_cmd;
  logic       w_end;
  logic [1:0] w_ev;

  always_comb begin
    w_ev         = data_in_i[5:4];
    w_phy_state  = (state_q == TURN_IN) || (state_q == PHY_CMD) ||
                   (state_q == PKT)     || (state_q == REG_RD);
    w_fall       = w_phy_state && !dir_i;
    w_cmd        = dir_i && !nxt_i && ((state_q == PHY_CMD) || (state_q == PKT));
    w_byte       = dir_i && nxt_i && (state_q == PKT);
    w_reg_cap    = dir_i && (state_q == REG_RD);
    w_start_turn = dir_i && nxt_i && ((state_q == LINK_OWN) || (state_q == TURN_OUT));
    w_start_cmd  = w_cmd && (w_ev == 2'b01) && !rx_active_q;
    // A packet closes either on the bus being handed back or on RxEvent=00.
    w_end        = rx_active_q && (w_fall || (w_cmd && (w_ev == 2'b00)));
  end

  always_ff @(posedge clk_usb_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state_q        <= LINK_OWN;
      dir_q          <= 1'b0;
      rx_cmd_q       <= 8'h00;
      rx_cmd_valid_q <= 1'b0;
      rx_active_q    <= 1'b0;
      rx_error_q     <= 1'b0;
      host_disc_q    <= 1'b0;
      pkt_data_q     <= 8'h00;
      pkt_valid_q    <= 1'b0;
      pkt_eop_q      <= 1'b0;
      pkt_len_q      <= 11'd0;
      pkt_ovf_q      <= 1'b0;
      reg_data_q     <= 8'h00;
      reg_valid_q    <= 1'b0;
      count_q        <= 11'd0;
    end else begin
      dir_q          <= dir_i;
      rx_cmd_valid_q <= 1'b0;
      pkt_valid_q    <= 1'b0;
      pkt_eop_q      <= 1'b0;
      pkt_ovf_q      <= 1'b0;
      reg_valid_q    <= 1'b0;

      case (state_q)
        LINK_OWN, TURN_OUT: state_q <= dir_i ? TURN_IN : LINK_OWN;
        TURN_IN: begin
          if (!dir_i)           state_q <= TURN_OUT;
          else if (rx_active_q) state_q <= PKT;
          else if (rd_expect_i) state_q <= REG_RD;
          else                  state_q <= PHY_CMD;
        end
        PHY_CMD: begin
          if (!dir_i)           state_q <= TURN_OUT;
          else if (w_start_cmd) state_q <= PKT;
        end
        PKT: begin
          if (!dir_i)                       state_q <= TURN_OUT;
          else if (w_cmd && w_ev == 2'b00)  state_q <= PHY_CMD;
        end
        REG_RD:  state_q <= dir_i ? PHY_CMD : TURN_OUT;
        default: state_q <= LINK_OWN;
      endcase

      if (w_start_turn || w_start_cmd) begin
        rx_active_q <= 1'b1;
        count_q     <= 11'd0;
        rx_error_q  <= 1'b0;
      end

      if (w_cmd) begin
        rx_cmd_q       <= data_in_i;
        rx_cmd_valid_q <= 1'b1;
        host_disc_q    <= (w_ev == 2'b10);
        if (w_ev == 2'b11) rx_error_q <= 1'b1;
      end

      if (w_byte) begin
        pkt_data_q  <= data_in_i;
        pkt_valid_q <= 1'b1;
        if (count_q != 11'h7FF) count_q <= count_q + 11'd1;
      end

      if (w_reg_cap) begin
        reg_data_q  <= data_in_i;
        reg_valid_q <= 1'b1;
      end

      if (w_end) begin
        pkt_eop_q   <= 1'b1;
        pkt_len_q   <= count_q;
        pkt_ovf_q   <= ({1'b0, count_q} > c_max_pkt);
        rx_active_q <= 1'b0;
      end
    end
  end

  assign phy_owns_bus_o = dir_q;
  assign rx_cmd_o       = rx_cmd_q;
  assign rx_cmd_valid_o = rx_cmd_valid_q;
  assign linestate_o    = rx_cmd_q[1:0];
  assign vbus_state_o   = rx_cmd_q[3:2];
  assign id_gnd_o       = rx_cmd_q[6];
  assign alt_int_o      = rx_cmd_q[7];
  assign rx_active_o    = rx_active_q;
  assign rx_error_o     = rx_error_q;
  assign host_disc_o    = host_disc_q;
  assign pkt_data_o     = pkt_data_q;
  assign pkt_valid_o    = pkt_valid_q;
  assign pkt_eop_o      = pkt_eop_q;
  assign pkt_len_o      = pkt_len_q;
  assign pkt_ovf_o      = pkt_ovf_q;
  assign reg_data_o     = reg_data_q;
  assign reg_valid_o    = reg_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_ulpi_rx_link.sv
// ============================================================================
// Module   : tb_ulpi_rx_link
// Purpose  : Directed bench for ulpi_rx_link with a bus-turn based reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ulpi_rx_link;

  localparam int c_max = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dir = 1'b0;
  logic        nxt = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        rd_expect = 1'b0;

  logic        phy_owns, cmd_v, id_gnd, alt_int, rx_act, rx_err, disc;
  logic        pkt_v, eop, ovf, reg_v;
  logic [7:0]  rx_cmd, pkt_d, reg_d;
  logic [1:0]  ls, vb;
  logic [10:0] len;

  ulpi_rx_link #(.MAX_PKT(c_max)) dut (
    .clk_usb_i(clk), .sys_rst_n_i(rst_n), .dir_i(dir), .nxt_i(nxt),
    .data_in_i(data), .rd_expect_i(rd_expect),
    .phy_owns_bus_o(phy_owns), .rx_cmd_o(rx_cmd), .rx_cmd_valid_o(cmd_v),
    .linestate_o(ls), .vbus_state_o(vb), .id_gnd_o(id_gnd), .alt_int_o(alt_int),
    .rx_active_o(rx_act), .rx_error_o(rx_err), .host_disc_o(disc),
    .pkt_data_o(pkt_d), .pkt_valid_o(pkt_v), .pkt_eop_o(eop), .pkt_len_o(len),
    .pkt_ovf_o(ovf), .reg_data_o(reg_d), .reg_valid_o(reg_v)
  );

  always #8 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: position within the current DIR-high run drives everything.
  int         m_run, m_count;
  logic       m_active, m_err, m_disc, m_regmode;
  logic [7:0] m_rxcmd;
  logic       e_phy, e_cmdv, e_pktv, e_eop, e_ovf, e_regv;
  logic [7:0] e_pktd, e_regd;
  logic [10:0] e_len;

  // Observed events, cleared per scenario.
  logic [7:0] bytes_q[$];
  int eop_n, ovf_n, reg_n, cmd_n, last_len;
  logic [7:0] last_reg;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, a, e);
    end
  endtask

  task automatic pkt_start();
    m_active = 1'b1; m_count = 0; m_err = 1'b0;
  endtask

  task automatic pkt_finish();
    e_eop = 1'b1; e_len = 11'(m_count); e_ovf = (m_count > c_max); m_active = 1'b0;
  endtask

  task automatic model_cmd(input logic [7:0] x);
    m_rxcmd = x; e_cmdv = 1'b1;
    case (x[5:4])
      2'b01: if (!m_active) pkt_start();
      2'b00: if (m_active) pkt_finish();
      2'b11: m_err = 1'b1;
      default: ;
    endcase
    m_disc = (x[5:4] == 2'b10);
  endtask

  task automatic model_step(input logic r, d, n, input logic [7:0] x, input logic rd);
    int pos;
    e_cmdv = 0; e_pktv = 0; e_eop = 0; e_ovf = 0; e_regv = 0;
    if (!r) begin
      m_run = 0; m_count = 0; m_active = 0; m_err = 0; m_disc = 0; m_regmode = 0;
      m_rxcmd = 8'h00; e_phy = 0; e_len = 11'd0;
      return;
    end
    e_phy = d;
    if (d) begin
      pos = m_run;
      m_run++;
      if (pos == 0) begin
        if (n) pkt_start();
      end else if (pos == 1) begin
        m_regmode = rd && !m_active;
      end else if (pos == 2 && m_regmode) begin
        e_regv = 1'b1; e_regd = x;
      end else if (!n) begin
        model_cmd(x);
      end else if (m_active) begin
        e_pktv = 1'b1; e_pktd = x;
        if (m_count < 2047) m_count++;
      end
    end else begin
      if (m_run > 0 && m_active) pkt_finish();
      m_run = 0;
    end
  endtask

  task automatic compare();
    chk("phy_owns_bus", phy_owns, e_phy);
    chk("rx_cmd", rx_cmd, m_rxcmd);
    chk("rx_cmd_valid", cmd_v, e_cmdv);
    chk("linestate", ls, m_rxcmd[1:0]);
    chk("vbus_state", vb, m_rxcmd[3:2]);
    chk("id_gnd", id_gnd, m_rxcmd[6]);
    chk("alt_int", alt_int, m_rxcmd[7]);
    chk("rx_active", rx_act, m_active);
    chk("rx_error", rx_err, m_err);
    chk("host_disc", disc, m_disc);
    chk("pkt_valid", pkt_v, e_pktv);
    if (e_pktv) chk("pkt_data", pkt_d, e_pktd);
    chk("pkt_eop", eop, e_eop);
    if (e_eop) chk("pkt_len", len, e_len);
    chk("pkt_ovf", ovf, e_ovf);
    chk("reg_valid", reg_v, e_regv);
    if (e_regv) chk("reg_data", reg_d, e_regd);
    if (pkt_v) bytes_q.push_back(pkt_d);
    if (eop) begin eop_n++; last_len = int'(len); end
    if (ovf) ovf_n++;
    if (reg_v) begin reg_n++; last_reg = reg_d; end
    if (cmd_v) cmd_n++;
  endtask

  task automatic cyc(input logic r, d, n, input logic [7:0] x, input logic rd);
    @(negedge clk);
    rst_n = r; dir = d; nxt = n; data = x; rd_expect = rd;
    if (!r) begin
      #1;
      chk("reset_outputs_zero",
          {13'd0, phy_owns, rx_cmd, cmd_v, ls, vb, id_gnd, alt_int, rx_act, rx_err,
           disc, pkt_d, pkt_v, eop, len, ovf, reg_d, reg_v}, 64'd0);
    end
    model_step(r, d, n, x, rd);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic clr();
    bytes_q.delete(); eop_n = 0; ovf_n = 0; reg_n = 0; cmd_n = 0; last_len = -1;
    last_reg = 8'h00;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1, 0, 0, 8'h00, 0);
  endtask

  initial begin
    model_step(0, 0, 0, 8'h00, 0);
    clr();
    cyc(0, 0, 0, 8'h00, 0);
    cyc(0, 1, 1, 8'hFF, 1);
    idle(2);
    chk("reset_state_active", rx_act, 1'b0);

    // RX CMD 0x05 outside a packet
    clr();
    cyc(1, 1, 0, 8'h00, 0);
    cyc(1, 1, 0, 8'hFF, 0);
    cyc(1, 1, 0, 8'h05, 0);
    cyc(1, 0, 0, 8'h00, 0);
    idle(1);
    chk("s1_cmd_count", cmd_n, 1);
    chk("s1_linestate", ls, 2'b01);
    chk("s1_vbus", vb, 2'b01);
    chk("s1_rx_active", rx_act, 1'b0);

    // Four-byte packet closed by DIR falling
    clr();
    cyc(1, 1, 1, 8'h00, 0);
    cyc(1, 1, 1, 8'hEE, 0);
    cyc(1, 1, 1, 8'hA5, 0);
    cyc(1, 1, 1, 8'h5A, 0);
    cyc(1, 1, 1, 8'hC3, 0);
    cyc(1, 1, 1, 8'h3C, 0);
    cyc(1, 0, 0, 8'h00, 0);
    idle(1);
    chk("s2_nbytes", bytes_q.size(), 4);
    if (bytes_q.size() == 4)
      chk("s2_bytes", {bytes_q[0], bytes_q[1], bytes_q[2], bytes_q[3]}, 32'hA55AC33C);
    chk("s2_eop_count", eop_n, 1);
    chk("s2_len", last_len, 4);
    chk("s2_ovf_count", ovf_n, 0);

    // RxEvent=11 inside packet, then 0x00 terminates
    clr();
    cyc(1, 1, 1, 8'h00, 0);
    cyc(1, 1, 1, 8'h00, 0);
    cyc(1, 1, 1, 8'h11, 0);
    cyc(1, 1, 0, 8'h30, 0);
    cyc(1, 1, 1, 8'h22, 0);
    cyc(1, 1, 0, 8'h00, 0);
    cyc(1, 1, 0, 8'h02, 0);
    cyc(1, 0, 0, 8'h00, 0);
    idle(1);
    chk("s3_nbytes", bytes_q.size(), 2);
    chk("s3_eop_count", eop_n, 1);
    chk("s3_len", last_len, 2);
    chk("s3_rx_error", rx_err, 1'b1);

    // Register read response
    clr();
    cyc(1, 1, 0, 8'h00, 1);
    cyc(1, 1, 0, 8'hFF, 1);
    cyc(1, 1, 0, 8'h41, 1);
    cyc(1, 0, 0, 8'h00, 1);
    idle(1);
    chk("s4_reg_count", reg_n, 1);
    chk("s4_reg_data", last_reg, 8'h41);
    chk("s4_cmd_count", cmd_n, 0);

    // Register read aborted by DIR falling in the capture slot
    clr();
    cyc(1, 1, 0, 8'h00, 1);
    cyc(1, 1, 0, 8'hFF, 1);
    cyc(1, 0, 0, 8'h42, 1);
    idle(1);
    chk("s4b_reg_count", reg_n, 0);

    // Overflow: six bytes against MAX_PKT=4
    clr();
    cyc(1, 1, 1, 8'h00, 0);
    cyc(1, 1, 1, 8'h00, 0);
    for (int i = 1; i <= 6; i++) cyc(1, 1, 1, 8'(i), 0);
    cyc(1, 0, 0, 8'h00, 0);
    idle(1);
    chk("s5_nbytes", bytes_q.size(), 6);
    chk("s5_len", last_len, 6);
    chk("s5_ovf_count", ovf_n, 1);

    // Back-to-back turns, then RxEvent=01 start plus host-disconnect decode
    clr();
    cyc(1, 1, 1, 8'h00, 0);
    cyc(1, 1, 1, 8'h00, 0);
    cyc(1, 1, 1, 8'h99, 0);
    cyc(1, 0, 0, 8'h00, 0);
    cyc(1, 1, 1, 8'h00, 0);
    cyc(1, 1, 1, 8'h00, 0);
    cyc(1, 1, 1, 8'h98, 0);
    cyc(1, 1, 0, 8'h20, 0);
    chk("s6_host_disc", disc, 1'b1);
    cyc(1, 1, 0, 8'h05, 0);
    cyc(1, 0, 0, 8'h00, 0);
    cyc(1, 1, 0, 8'h00, 0);
    cyc(1, 1, 0, 8'h00, 0);
    cyc(1, 1, 0, 8'h10, 0);
    cyc(1, 1, 1, 8'h77, 0);
    cyc(1, 1, 0, 8'h00, 0);
    cyc(1, 0, 0, 8'h00, 0);
    idle(1);
    chk("s6_eop_count", eop_n, 3);
    chk("s6_last_len", last_len, 1);

    // Reset mid-packet after two bytes
    clr();
    cyc(1, 1, 1, 8'h00, 0);
    cyc(1, 1, 1, 8'h00, 0);
    cyc(1, 1, 1, 8'hAA, 0);
    cyc(1, 1, 1, 8'hBB, 0);
    cyc(0, 1, 1, 8'hCC, 0);
    cyc(0, 1, 0, 8'h00, 0);
    idle(3);
    chk("s7_eop_count", eop_n, 0);
    chk("s7_nbytes", bytes_q.size(), 2);
    chk("s7_rx_active", rx_act, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ulpi_rx_link.md
ULPI_RX_LINK -- requirements
Module: ulpi_rx_link

Interface
REQ-001 Parameter MAX_PKT, default 1024, maximum data bytes accepted per received packet before overflow is flagged.
REQ-002 CLK_USB  input  1  ULPI 60 MHz clock; all logic on its rising edge.
REQ-003 SYS_RST_N  input  1  reset, asynchronous, active-low.
REQ-004 DIR  input  1  ULPI bus direction from PHY; 1 = PHY drives DATA.
REQ-005 NXT  input  1  ULPI NXT from PHY.
REQ-006 DATA_IN  input  8  ULPI data bus as sampled by the link.
REQ-007 RD_EXPECT  input  1  level; high while the link transmitter awaits a register-read response.
REQ-008 PHY_OWNS_BUS  output  1  registered DIR; high while PHY owns the bus, including turnaround cycles.
REQ-009 RX_CMD  output  8  last received RX CMD byte; RX_CMD_VALID  output  1  one-cycle pulse per RX CMD.
REQ-010 LINESTATE  output  2  RX_CMD[1:0]; VBUS_STATE  output  2  RX_CMD[3:2]; ID_GND output 1 RX_CMD[6]; ALT_INT output 1 RX_CMD[7].
REQ-011 RX_ACTIVE  output  1  high while a receive packet is in progress; RX_ERROR  output  1  sticky per packet, RxEvent=11 seen; HOST_DISC  output  1  RxEvent=10.
REQ-012 PKT_DATA  output  8; PKT_VALID  output  1  one-cycle pulse per packet data byte.
REQ-013 PKT_EOP  output  1  one-cycle pulse at packet end; PKT_LEN  output  11  byte count of the packet, valid with PKT_EOP.
REQ-014 PKT_OVF  output  1  pulse with PKT_EOP when byte count exceeded MAX_PKT.
REQ-015 REG_DATA  output  8; REG_VALID  output  1  one-cycle pulse when a register-read response byte is captured.

Function
REQ-016 States: LINK_OWN, TURN_IN, PHY_CMD, PKT, REG_RD, TURN_OUT; state and all outputs update on the rising edge of CLK_USB.
REQ-017 LINK_OWN: DIR=0; on DIR 0->1 enter TURN_IN; if NXT=1 in that cycle, set RX_ACTIVE=1 and clear byte count and RX_ERROR (packet start).
REQ-018 TURN_IN: DATA_IN ignored for exactly one cycle; next state REG_RD if RD_EXPECT=1 and RX_ACTIVE=0, PKT if RX_ACTIVE=1, else PHY_CMD.
REQ-019 PHY_CMD/PKT: DIR=1 and NXT=0 -> byte is an RX CMD: latch RX_CMD, pulse RX_CMD_VALID, decode fields of REQ-010/011.
REQ-020 RX CMD RxEvent: 01 sets RX_ACTIVE and moves PHY_CMD->PKT; 00 while in PKT ends the packet (PKT_EOP, RX_ACTIVE=0, -> PHY_CMD); 11 sets RX_ERROR; 10 sets HOST_DISC, cleared by next RX CMD with RxEvent!=10.
REQ-021 PKT: DIR=1 and NXT=1 -> data byte: PKT_DATA<=DATA_IN, PKT_VALID pulse, byte count +1; count saturates at 2047.
REQ-022 Bytes beyond MAX_PKT still produce PKT_VALID; PKT_OVF pulses with the closing PKT_EOP.
REQ-023 REG_RD: first cycle after TURN_IN with DIR=1 captures REG_DATA, pulses REG_VALID once; further DIR=1 cycles are treated as RX CMDs (PHY_CMD).
REQ-024 DIR 1->0 in any PHY-owned state -> TURN_OUT for one cycle, DATA_IN ignored; if RX_ACTIVE, PKT_EOP pulses in the TURN_OUT cycle and RX_ACTIVE clears.
REQ-025 TURN_OUT -> LINK_OWN; DIR 0->1 during TURN_OUT -> TURN_IN (back-to-back), RX_ACTIVE rule of REQ-017 applies.
REQ-026 DIR 1->0 in the REG_RD capture cycle -> no REG_VALID; register read treated as aborted.
REQ-027 PKT_VALID, RX_CMD_VALID, REG_VALID never pulse in the same cycle; PKT_EOP may coincide with RX_CMD_VALID only for RxEvent=00 termination.
REQ-028 PKT_LEN equals number of PKT_VALID pulses since packet start (saturated), presented in the PKT_EOP cycle.

Reset
REQ-029 SYS_RST_N=0 asynchronously forces LINK_OWN and all outputs to 0, except LINESTATE/VBUS_STATE/RX_CMD = 0.
REQ-030 Reset release takes effect at the first rising edge with SYS_RST_N=1; a packet interrupted by reset produces no PKT_EOP.

Verification
REQ-031 DIR 0->1 with NXT=0, then RX CMD 0x05 -> one RX_CMD_VALID, LINESTATE=01, VBUS_STATE=01, RX_ACTIVE=0.
REQ-032 DIR 0->1 with NXT=1, 4 bytes A5,5A,C3,3C with NXT=1, DIR->0 -> four PKT_VALID in order, PKT_EOP in TURN_OUT cycle, PKT_LEN=4.
REQ-033 Packet with interleaved NXT=0 byte 0x30 (RxEvent=11) then RX CMD 0x00 -> RX_ERROR=1, PKT_EOP on the 0x00 CMD, no PKT_VALID for CMD bytes.
REQ-034 RD_EXPECT=1, DIR 0->1 NXT=0, turnaround, DATA_IN=0x41, DIR->0 -> REG_DATA=0x41, exactly one REG_VALID.
REQ-035 MAX_PKT=4, 6 data bytes -> six PKT_VALID, PKT_LEN=6, PKT_OVF pulse with PKT_EOP.
REQ-036 SYS_RST_N low mid-packet after 2 bytes -> all outputs 0 immediately, no PKT_EOP after release.
